cordic_atan2: RTL

- Iterative CORDIC in vectoring mode; the inverse of the team's sin/cos rotation CORDIC.
- Takes a signed Cartesian pair (x, y) and returns the phase in degrees plus the gain-compensated magnitude.
- Phase output uses the same unsigned degrees Q.EXPAND_BIT format that the sin/cos block accepts; example: 120° = 32'd7864320.
- Sits in the demodulation / loop-back path: its phase output can feed the sin/cos block directly.

---
 rtl/cordic_atan2.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cordic_atan2.sv
// Iterative vectoring-mode CORDIC: converts a signed (x, y) pair into an unsigned
// phase in degrees Q.EXPAND_BIT and a gain-compensated magnitude. ITERATIONS: 8..EXPAND_BIT.
module cordic_atan2 #(
    parameter int DATA_WIDTH = 32,
    parameter int EXPAND_BIT = 16,
    parameter int ITERATIONS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic [DATA_WIDTH-1:0] y_in,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] phase,
    output logic [DATA_WIDTH-1:0] magnitude
);

    // Two guard bits cover the CORDIC gain (< 2.33) and negating the most negative input.
    localparam int IW = DATA_WIDTH + 2;
    localparam int CW = $clog2(ITERATIONS + 1);

    localparam logic signed [IW-1:0] DEG180 = IW'(64'sd180 <<< EXPAND_BIT);
    localparam logic signed [IW-1:0] DEG360 = IW'(64'sd360 <<< EXPAND_BIT);
    localparam logic signed [63:0]   K_FACTOR = ((64'sd39797 <<< EXPAND_BIT) + 64'sd32768) >>> 16;

    typedef enum logic [2:0] {
        IDLE,
        PREROT,
        ITER,
        SCALE,
        DONE
    } state_t;

    state_t                 state;
    logic signed [IW-1:0]   x_reg;
    logic signed [IW-1:0]   y_reg;
    logic signed [IW-1:0]   z_reg;
    logic [CW-1:0]          iter;
    logic                   y_zero;
    logic signed [63:0]     x_wide;
    logic [DATA_WIDTH-1:0]  phase_wrapped;

    // Arctangent table in Q16 degrees, rescaled with rounding to EXPAND_BIT.
    function automatic logic signed [IW-1:0] atan_lut(input logic [CW-1:0] idx);
        longint q16;
        case (int'(idx))
            0:       q16 = 64'sd2949120;
            1:       q16 = 64'sd1740967;
            2:       q16 = 64'sd919879;
            3:       q16 = 64'sd466945;
            4:       q16 = 64'sd234379;
            5:       q16 = 64'sd117304;
            6:       q16 = 64'sd58666;
            7:       q16 = 64'sd29335;
            8:       q16 = 64'sd14668;
            9:       q16 = 64'sd7334;
            10:      q16 = 64'sd3667;
            11:      q16 = 64'sd1833;
            12:      q16 = 64'sd917;
            13:      q16 = 64'sd458;
            14:      q16 = 64'sd229;
            15:      q16 = 64'sd115;
            default: q16 = 64'sd0;
        endcase
        atan_lut = IW'(((q16 <<< EXPAND_BIT) + 64'sd32768) >>> 16);
    endfunction

    always_comb begin
        x_wide = {{(64-IW){x_reg[IW-1]}}, x_reg};
    end

    always_comb begin
        phase_wrapped = DATA_WIDTH'(z_reg);
        if (z_reg < 0) begin
            phase_wrapped = DATA_WIDTH'(z_reg + DEG360);
        end else if (z_reg >= DEG360) begin
            phase_wrapped = DATA_WIDTH'(z_reg - DEG360);
        end
    end

    // Inputs on the x axis (y == 0) keep the pre-rotation angle, so 0 and 180 degrees
    // come out exact and the origin reports phase 0; x still iterates for the magnitude.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            phase     <= '0;
            magnitude <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            iter      <= '0;
            y_zero    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg    <= {{2{x_in[DATA_WIDTH-1]}}, x_in};
                        y_reg    <= {{2{y_in[DATA_WIDTH-1]}}, y_in};
                        y_zero   <= (y_in == '0);
                        in_ready <= 1'b0;
                        state    <= PREROT;
                    end
                end
                PREROT: begin
                    if (x_reg[IW-1]) begin
                        x_reg <= -x_reg;
                        y_reg <= -y_reg;
                        z_reg <= DEG180;
                    end else begin
                        z_reg <= '0;
                    end
                    iter  <= '0;
                    state <= ITER;
                end
                ITER: begin
                    if (!y_reg[IW-1]) begin
                        x_reg <= x_reg + (y_reg >>> iter);
                        y_reg <= y_reg - (x_reg >>> iter);
                        if (!y_zero) begin
                            z_reg <= z_reg + atan_lut(iter);
                        end
                    end else begin
                        x_reg <= x_reg - (y_reg >>> iter);
                        y_reg <= y_reg + (x_reg >>> iter);
                        if (!y_zero) begin
                            z_reg <= z_reg - atan_lut(iter);
                        end
                    end
                    if (iter == CW'(ITERATIONS - 1)) begin
                        state <= SCALE;
                    end else begin
                        iter <= iter + CW'(1);
                    end
                end
                SCALE: begin
                    magnitude <= DATA_WIDTH'((x_wide * K_FACTOR) >>> EXPAND_BIT);
                    phase     <= phase_wrapped;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
